video_layer_mixer: RTL and testbench

Parametrised N-layer RGB compositor; successor to the two-input fixed-key mixer between the video sources (Pi DPI background, AIV overlay, future layers) and the SCART output. Per-pixel colour-key transparency, fixed layer priority, and a frame-stepped alpha fade engine that cross-fades the composited foreground against the background. Runs on the 6x system clock and updates once per pixel slot.

---
 rtl/video_layer_mixer.sv | 170 +++++++++++++++++
 tb/tb_video_layer_mixer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_layer_mixer.sv
// Colour-keyed N-layer RGB compositor; 3 sysClk latency from the SAMPLE_PHASE sample, output held for the pixel slot, no backpressure.
// Define VIDEO_LAYER_MIXER_FADE_EN for the frame-stepped alpha fade engine; otherwise a hard key at full alpha.
module video_layer_mixer #(
   parameter int CHANNELS     = 2,
   parameter int BPC          = 6,
   parameter int ALPHA_W      = 4,
   parameter int SAMPLE_PHASE = 0,
   parameter int FRAME_DIV_W  = 4
) (
   input  logic                      sysClk,
   input  logic                      nReset,
   input  logic [2:0]                sysClkPhase,
   input  logic                      frameStart,
   input  logic [CHANNELS*3*BPC-1:0] rgbIn,
   input  logic [CHANNELS-1:0]       layerEnable,
   input  logic [3*BPC-1:0]          keyColour,
   input  logic                      fadeStart,
   input  logic [ALPHA_W:0]          fadeTarget,
   input  logic [FRAME_DIV_W-1:0]    fadeRate,
   output logic [3*BPC-1:0]          rgbOut,
   output logic                      fgVisible,
   output logic                      fadeBusy,
   output logic [ALPHA_W:0]          alphaLevel
);

   localparam int PW = 3*BPC;
   localparam logic [ALPHA_W:0] ALPHA_MAX = {1'b1, {ALPHA_W{1'b0}}};
   localparam logic [2:0] PH_S1  = 3'(SAMPLE_PHASE);
   localparam logic [2:0] PH_S2  = 3'(SAMPLE_PHASE + 1);
   localparam logic [2:0] PH_S3  = 3'(SAMPLE_PHASE + 2);
   localparam logic [2:0] PH_OUT = 3'(SAMPLE_PHASE + 3);

   logic [CHANNELS*PW-1:0] rgb_s1;
   logic [CHANNELS-1:0]    en_s1;
   logic [PW-1:0]          key_s1;
   logic [PW-1:0]          bg_sel, fg_sel, bg_s2, fg_s2, mix, pix_s3;
   logic                   hit_sel, hit_s2, hit_s3;

   // Ascending scan so the highest-index visible layer wins.
   always_comb begin
      bg_sel  = en_s1[0] ? rgb_s1[PW-1:0] : '0;
      fg_sel  = '0;
      hit_sel = 1'b0;
      for (int k = 1; k < CHANNELS; k++) begin
         if (en_s1[k] && (rgb_s1[k*PW +: PW] != key_s1)) begin
            fg_sel  = rgb_s1[k*PW +: PW];
            hit_sel = 1'b1;
         end
      end
   end

`ifdef VIDEO_LAYER_MIXER_FADE_EN
   localparam int PRODW = BPC + ALPHA_W + 1;
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_FADING = 1'b1;
   localparam logic [ALPHA_W:0]     ALPHA_ONE = {{ALPHA_W{1'b0}}, 1'b1};
   localparam logic [FRAME_DIV_W:0] DIV_ONE   = {{FRAME_DIV_W{1'b0}}, 1'b1};

   logic [0:0]             fade_state;
   logic [ALPHA_W:0]       alpha_q, target_q, tgt_clamp, alpha_step, alpha_s1, alpha_s2;
   logic [FRAME_DIV_W-1:0] rate_q, div_q, rate_eff;
   logic [FRAME_DIV_W:0]   div_inc;
   logic [PW-1:0]          blend_sel;

   function automatic logic [BPC-1:0] blend(input logic [BPC-1:0] f, input logic [BPC-1:0] b,
                                            input logic [ALPHA_W:0] a);
      logic [PRODW-1:0] pf, pb;
      pf = PRODW'(f) * PRODW'(a);
      pb = PRODW'(b) * PRODW'(ALPHA_MAX - a);
      return BPC'((pf + pb) >> ALPHA_W);
   endfunction

   always_comb begin
      blend_sel = '0;
      for (int c = 0; c < 3; c++)
         blend_sel[c*BPC +: BPC] = blend(fg_s2[c*BPC +: BPC], bg_s2[c*BPC +: BPC], alpha_s2);
   end

   assign mix        = hit_s2 ? blend_sel : bg_s2;
   assign tgt_clamp  = (fadeTarget > ALPHA_MAX) ? ALPHA_MAX : fadeTarget;
   assign rate_eff   = (rate_q == '0) ? {{(FRAME_DIV_W-1){1'b0}}, 1'b1} : rate_q;
   assign div_inc    = {1'b0, div_q} + DIV_ONE;
   assign alpha_step = (alpha_q < target_q) ? alpha_q + ALPHA_ONE : alpha_q - ALPHA_ONE;
   assign alphaLevel = alpha_q;
   assign fadeBusy   = (fade_state == ST_FADING);

   // A fadeStart takes precedence over a coincident frameStart, which is then not counted.
   always_ff @(posedge sysClk or negedge nReset) begin
      if (!nReset) begin
         fade_state <= ST_IDLE;
         alpha_q    <= ALPHA_MAX;
         target_q   <= ALPHA_MAX;
         rate_q     <= '0;
         div_q      <= '0;
      end else if (fade_state == ST_IDLE) begin
         if (fadeStart && (tgt_clamp != alpha_q)) begin
            fade_state <= ST_FADING;
            target_q   <= tgt_clamp;
            rate_q     <= fadeRate;
            div_q      <= '0;
         end
      end else if (fadeStart) begin
         target_q <= tgt_clamp;
         rate_q   <= fadeRate;
         div_q    <= '0;
         if (tgt_clamp == alpha_q) fade_state <= ST_IDLE;
      end else if (frameStart) begin
         if (div_inc >= {1'b0, rate_eff}) begin
            div_q   <= '0;
            alpha_q <= alpha_step;
            if (alpha_step == target_q) fade_state <= ST_IDLE;
         end else begin
            div_q <= div_inc[FRAME_DIV_W-1:0];
         end
      end
   end

   always_ff @(posedge sysClk or negedge nReset) begin
      if (!nReset) begin
         alpha_s1 <= '0;
         alpha_s2 <= '0;
      end else begin
         if (sysClkPhase == PH_S1) alpha_s1 <= alpha_q;
         if (sysClkPhase == PH_S2) alpha_s2 <= alpha_s1;
      end
   end
`else
   logic unused_fade;

   assign unused_fade = ^{frameStart, fadeStart, fadeTarget, fadeRate};
   assign mix         = hit_s2 ? fg_s2 : bg_s2;
   assign alphaLevel  = ALPHA_MAX;
   assign fadeBusy    = 1'b0;
`endif

   always_ff @(posedge sysClk or negedge nReset) begin
      if (!nReset) begin
         rgb_s1    <= '0;
         en_s1     <= '0;
         key_s1    <= '0;
         bg_s2     <= '0;
         fg_s2     <= '0;
         hit_s2    <= 1'b0;
         pix_s3    <= '0;
         hit_s3    <= 1'b0;
         rgbOut    <= '0;
         fgVisible <= 1'b0;
      end else begin
         if (sysClkPhase == PH_S1) begin
            rgb_s1 <= rgbIn;
            en_s1  <= layerEnable;
            key_s1 <= keyColour;
         end
         if (sysClkPhase == PH_S2) begin
            bg_s2  <= bg_sel;
            fg_s2  <= fg_sel;
            hit_s2 <= hit_sel;
         end
         if (sysClkPhase == PH_S3) begin
            pix_s3 <= mix;
            hit_s3 <= hit_s2;
         end
         if (sysClkPhase == PH_OUT) begin
            rgbOut    <= pix_s3;
            fgVisible <= hit_s3;
         end
      end
   end

endmodule

// File: tb/tb_video_layer_mixer.sv
// Directed and randomized checks of video_layer_mixer (3 layers, 6 bpc) against a per-pixel reference model.
module tb_video_layer_mixer;

   logic        sysClk;
   logic        nReset;
   logic [2:0]  sysClkPhase;
   logic        frameStart;
   logic [53:0] rgbIn;
   logic [2:0]  layerEnable;
   logic [17:0] keyColour;
   logic        fadeStart;
   logic [4:0]  fadeTarget;
   logic [3:0]  fadeRate;
   logic [17:0] rgbOut;
   logic        fgVisible;
   logic        fadeBusy;
   logic [4:0]  alphaLevel;

   int checks = 0;
   int errors = 0;
   int m_alpha = 16;
   logic [17:0] ch [3];
   logic [2:0]  en;
   logic [17:0] key;
   logic [18:0] exp_a, exp_b;

   video_layer_mixer #(.CHANNELS(3), .BPC(6), .ALPHA_W(4), .SAMPLE_PHASE(0), .FRAME_DIV_W(4)) dut (
      .sysClk(sysClk), .nReset(nReset), .sysClkPhase(sysClkPhase), .frameStart(frameStart),
      .rgbIn(rgbIn), .layerEnable(layerEnable), .keyColour(keyColour), .fadeStart(fadeStart),
      .fadeTarget(fadeTarget), .fadeRate(fadeRate), .rgbOut(rgbOut), .fgVisible(fgVisible),
      .fadeBusy(fadeBusy), .alphaLevel(alphaLevel)
   );

   initial begin
      sysClk = 1'b0;
      forever #5 sysClk = ~sysClk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge sysClk);
      #1;
      sysClkPhase = (sysClkPhase == 3'd5) ? 3'd0 : sysClkPhase + 3'd1;
      frameStart  = 1'b0;
      fadeStart   = 1'b0;
   endtask

   function automatic logic [17:0] rgb(input int r, input int g, input int b);
      return {6'(r), 6'(g), 6'(b)};
   endfunction

   // Background, then the first visible layer scanning from the top, then a linear alpha mix.
   function automatic logic [18:0] model(input int a);
      logic [17:0] bg, fg, res;
      bit found;
      int f, b;
      bg    = en[0] ? ch[0] : 18'd0;
      fg    = 18'd0;
      res   = 18'd0;
      found = 0;
      for (int k = 2; k >= 1; k--)
         if (!found && en[k] && ch[k] != key) begin
            fg    = ch[k];
            found = 1;
         end
      if (!found) return {1'b0, bg};
      for (int c = 0; c < 3; c++) begin
         f = int'(fg[c*6 +: 6]);
         b = int'(bg[c*6 +: 6]);
         res[c*6 +: 6] = 6'((f * a + b * (16 - a)) / 16);
      end
      return {1'b1, res};
   endfunction

   task automatic apply();
      rgbIn       = {ch[2], ch[1], ch[0]};
      layerEnable = en;
      keyColour   = key;
   endtask

   task automatic run_pixel(input string tag);
      logic [18:0] e;
      apply();
      while (sysClkPhase != 3'd0) step();
      e = model(m_alpha);
      repeat (4) step();
      check(tag, {13'd0, fgVisible, rgbOut}, {13'd0, e});
   endtask

   initial begin
      nReset = 1'b1; sysClkPhase = 3'd0; frameStart = 1'b0; fadeStart = 1'b0;
      fadeTarget = 5'd0; fadeRate = 4'd0; rgbIn = '0; layerEnable = '0; keyColour = '0;
      ch[0] = '0; ch[1] = '0; ch[2] = '0; en = '0; key = '0;
      #2 nReset = 1'b0;
      #1;
      check("rst_rgb", {14'd0, rgbOut}, 32'd0);
      check("rst_vis", {31'd0, fgVisible}, 32'd0);
      check("rst_busy", {31'd0, fadeBusy}, 32'd0);
      check("rst_alpha", {27'd0, alphaLevel}, 32'd16);
      step(); step();
      #1 nReset = 1'b1;

      // keying with layer 2 disabled
      en = 3'b011; key = rgb(0, 0, 0);
      ch[0] = rgb(10, 20, 30); ch[1] = rgb(0, 0, 0);
      run_pixel("key_transparent");
      check("key_bg_const", {13'd0, fgVisible, rgbOut}, {13'd0, 1'b0, rgb(10, 20, 30)});
      ch[1] = rgb(63, 0, 0);
      run_pixel("key_opaque");
      check("key_fg_const", {13'd0, fgVisible, rgbOut}, {13'd0, 1'b1, rgb(63, 0, 0)});

      // priority
      ch[1] = rgb(5, 5, 5); ch[2] = rgb(40, 40, 40); en = 3'b111;
      run_pixel("prio_top");
      check("prio_top_const", {14'd0, rgbOut}, {14'd0, rgb(40, 40, 40)});
      en = 3'b011;
      run_pixel("prio_l2_off");
      en = 3'b110; ch[1] = key; ch[2] = key;
      run_pixel("prio_all_keyed");
      check("prio_black_const", {13'd0, fgVisible, rgbOut}, 32'd0);

      // input change mid-slot only shows up after the next sample
      en = 3'b011; ch[0] = rgb(1, 2, 3); ch[1] = rgb(7, 8, 9);
      run_pixel("tim_a");
      exp_a = model(m_alpha);
      while (sysClkPhase != 3'd1) step();
      ch[1] = rgb(50, 51, 52);
      apply();
      exp_b = model(m_alpha);
      for (int i = 0; i < 8; i++) begin
         step();
         check("tim_hold", {13'd0, fgVisible, rgbOut}, {13'd0, exp_a});
      end
      step();
      check("tim_update_ph3", {13'd0, fgVisible, rgbOut}, {13'd0, exp_b});
      for (int i = 0; i < 5; i++) begin
         step();
         check("tim_stable", {13'd0, fgVisible, rgbOut}, {13'd0, exp_b});
      end

      // randomized layers with frequent key hits
      for (int n = 0; n < 24; n++) begin
         key = 18'($urandom_range(0, 3));
         for (int k = 0; k < 3; k++)
            ch[k] = ($urandom_range(0, 2) == 0) ? key : 18'($urandom);
         en = 3'($urandom);
         run_pixel("rand_pixel");
      end

      // asynchronous reset mid-frame
      en = 3'b011; key = rgb(0, 0, 0); ch[0] = rgb(10, 20, 30); ch[1] = rgb(63, 0, 0);
      run_pixel("pre_reset");
      nReset = 1'b0;
      #1;
      check("mid_rst_rgb", {14'd0, rgbOut}, 32'd0);
      check("mid_rst_vis", {31'd0, fgVisible}, 32'd0);
      check("mid_rst_busy", {31'd0, fadeBusy}, 32'd0);
      check("mid_rst_alpha", {27'd0, alphaLevel}, 32'd16);
      step();
      #1 nReset = 1'b1;
      while (sysClkPhase != 3'd3) begin
         step();
         check("post_rst_hold", {13'd0, fgVisible, rgbOut}, 32'd0);
      end
      step();
      check("post_rst_first", {13'd0, fgVisible, rgbOut}, {13'd0, 1'b1, rgb(63, 0, 0)});

`ifdef VIDEO_LAYER_MIXER_FADE_EN
      fadeTarget = 5'd20; fadeRate = 4'd1; fadeStart = 1'b1;
      step();
      check("clamp_idle_busy", {31'd0, fadeBusy}, 32'd0);
      check("clamp_idle_alpha", {27'd0, alphaLevel}, 32'd16);

      fadeTarget = 5'd8; fadeRate = 4'd2; fadeStart = 1'b1;
      step();
      check("fade_start_busy", {31'd0, fadeBusy}, 32'd1);
      for (int n = 1; n <= 16; n++) begin
         frameStart = 1'b1;
         step();
         check("fade_alpha", {27'd0, alphaLevel}, 32'(16 - n / 2));
         check("fade_busy", {31'd0, fadeBusy}, (n < 16) ? 32'd1 : 32'd0);
         step();
      end

      m_alpha = 8;
      en = 3'b011; key = rgb(1, 1, 1); ch[0] = rgb(0, 0, 0); ch[1] = rgb(63, 0, 0);
      run_pixel("fade_blend");
      check("fade_blend_r", {26'd0, rgbOut[17:12]}, 32'd31);

      fadeTarget = 5'd20; fadeRate = 4'd1; fadeStart = 1'b1;
      step();
      check("reclamp_busy", {31'd0, fadeBusy}, 32'd1);
      frameStart = 1'b1;
      step();
      check("reclamp_step", {27'd0, alphaLevel}, 32'd9);

      fadeTarget = 5'd16; fadeRate = 4'd3; fadeStart = 1'b1; frameStart = 1'b1;
      step();
      check("coinc_no_step", {27'd0, alphaLevel}, 32'd9);
      check("coinc_busy", {31'd0, fadeBusy}, 32'd1);
      for (int n = 1; n <= 3; n++) begin
         frameStart = 1'b1;
         step();
         check("coinc_div", {27'd0, alphaLevel}, (n < 3) ? 32'd9 : 32'd10);
      end

      nReset = 1'b0;
      #1;
      check("fade_rst_alpha", {27'd0, alphaLevel}, 32'd16);
      check("fade_rst_busy", {31'd0, fadeBusy}, 32'd0);
      step();
      #1 nReset = 1'b1;

      fadeTarget = 5'd14; fadeRate = 4'd0; fadeStart = 1'b1;
      step();
      frameStart = 1'b1;
      step();
      check("rate0_step", {27'd0, alphaLevel}, 32'd15);
      check("rate0_busy", {31'd0, fadeBusy}, 32'd1);
      fadeTarget = 5'd15; fadeRate = 4'd0; fadeStart = 1'b1;
      step();
      check("retgt_same_busy", {31'd0, fadeBusy}, 32'd0);
      frameStart = 1'b1;
      step();
      check("retgt_same_alpha", {27'd0, alphaLevel}, 32'd15);
`else
      fadeTarget = 5'd8; fadeRate = 4'd1; fadeStart = 1'b1;
      step();
      check("nofade_busy", {31'd0, fadeBusy}, 32'd0);
      for (int n = 0; n < 3; n++) begin
         frameStart = 1'b1;
         step();
      end
      check("nofade_alpha", {27'd0, alphaLevel}, 32'd16);
      en = 3'b011; key = rgb(1, 1, 1); ch[0] = rgb(0, 0, 0); ch[1] = rgb(63, 0, 0);
      run_pixel("hard_key");
      check("hard_key_r", {26'd0, rgbOut[17:12]}, 32'd63);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
